branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the 3-bit branch opcode (bu_op) produced by the control unit's branch decoder.
- Evaluates conditional jumps (JZ/JN/JC/JV) against the condition-code flags and resolves LOOP by decrementing Ra and testing the result.
- On a taken branch, issues a registered PC redirect and runs a flush sequencer that squashes the wrong-path instructions in IF/ID and ID/EX.
- Also keeps saturating branch/taken event counters for debug.

Parameters:
- DATA_W, 8, datapath width of the register values and the PC.
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken branch (1..3).
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- ex_valid  input  1  the EX-stage instruction is valid.
- stall  input  1  pipeline hold; freezes all state for the cycle.
- bu_op  input  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JV, 101 LOOP, 110/111 reserved.
- flags  input  4  {V,C,N,Z} from the CCR.
- ra_val  input  DATA_W  R[ra], the loop counter.
- rb_val  input  DATA_W  R[rb], the branch target.
- pc_load  output  1  registered; load pc_target into the PC.
- pc_target  output  DATA_W  registered redirect address.
- flush_if_id  output  1  squash the IF/ID register.
- flush_id_ex  output  1  squash the ID/EX register.
- loop_wr_en  output  1  combinational; write loop_wr_data back to Ra this cycle.
- loop_wr_data  output  DATA_W  ra_val-1, modulo 2^DATA_W.
- branch_cnt  output  CNT_W  branch instructions resolved.
- taken_cnt  output  CNT_W  branches taken.

Behaviour:
- Instruction accept: accept = ex_valid & ~stall & (state==IDLE) & bu_op in 001..101.
- Condition per bu_op:
  - JZ uses flags[0], JN uses flags[1], JC uses flags[2], JV uses flags[3].
  - LOOP is taken when (ra_val-1) != 0. With ra_val=1 the result is 0: not taken. With ra_val=0 the result is 0xFF: taken (wrap).
- taken = accept & condition.
- LOOP write-back: loop_wr_en = accept & (bu_op==101), regardless of taken. loop_wr_data is always driven with ra_val-1.
- Redirect: on the edge after taken, pc_load=1 and pc_target=rb_val for exactly one cycle. pc_target holds its last value otherwise. Latency is 1 cycle from the EX evaluation.
- Flush FSM, states IDLE and FLUSH, with a down-counter fcnt:
  - IDLE -> FLUSH on taken; fcnt loads FLUSH_CYCLES-1.
  - In FLUSH: flush_if_id=flush_id_ex=1 (decoded from state, not registered separately). fcnt decrements each non-stalled cycle. FLUSH -> IDLE when fcnt==0 and ~stall.
  - ex_valid/bu_op are ignored while in FLUSH, because those instructions are wrong-path: no write-back, no count, no redirect.
- stall=1: state, fcnt, and counters hold. pc_load is forced 0 during stall cycles. A taken decision requires ~stall, so no redirect is lost.
- Reserved bu_op (110/111) or 000: treated as non-branch; no counting, no effect.
- Counters: branch_cnt increments on each accept; taken_cnt increments on each taken. Both saturate at all-ones and do not wrap.
- Reset values: state=IDLE, fcnt=0, pc_load=0, pc_target=0, flush_*=0, branch_cnt=0, taken_cnt=0.
- Reset mid-FLUSH aborts the sequence, and flush deasserts on the next cycle. rst has priority over stall.

Test Plan:
- JZ taken: flags=0001, bu_op=001, rb_val=0x3C, ex_valid=1 -> next cycle pc_load=1, pc_target=0x3C; flush_* high for 2 cycles; branch_cnt=1, taken_cnt=1.
- JC not taken: flags=1011, bu_op=011 -> no pc_load, no flush; branch_cnt increments, taken_cnt unchanged.
- LOOP boundaries:
  - ra_val=0x05 -> loop_wr_en=1, loop_wr_data=0x04, taken.
  - ra_val=0x01 -> loop_wr_data=0x00, not taken.
  - ra_val=0x00 -> loop_wr_data=0xFF, taken.
- Wrong-path squash: taken JN followed by a valid LOOP during FLUSH -> no loop_wr_en, counters unchanged, no second redirect.
- Stall: stall=1 in the first FLUSH cycle for 3 cycles -> flush stays asserted, fcnt frozen, total flush length = 2 unstalled cycles + 3 stalled; JV presented with stall=1 -> ignored.
- Reset/saturation:
  - rst asserted mid-FLUSH -> all outputs at reset values next cycle.
  - Preload near saturation (CNT_W=4, 16 taken branches) -> taken_cnt holds at 0xF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates JZ/JN/JC/JV/LOOP, issues a
// registered PC redirect on a taken branch, and squashes the wrong-path
// instructions in IF/ID and ID/EX with a short flush sequence. Saturating
// branch/taken event counters are kept for debug.
module branch_resolve_unit #(
    parameter int DATA_W       = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              stall,
    input  logic [2:0]        bu_op,
    input  logic [3:0]        flags,
    input  logic [DATA_W-1:0] ra_val,
    input  logic [DATA_W-1:0] rb_val,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              loop_wr_en,
    output logic [DATA_W-1:0] loop_wr_data,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [2:0] OP_JZ   = 3'b001;
    localparam logic [2:0] OP_JN   = 3'b010;
    localparam logic [2:0] OP_JC   = 3'b011;
    localparam logic [2:0] OP_JV   = 3'b100;
    localparam logic [2:0] OP_LOOP = 3'b101;

    // fcnt counts remaining unstalled flush cycles after the current one
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

    // Event counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && !(&v)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic              pc_load_q, pc_load_d;
    logic [DATA_W-1:0] pc_target_q, pc_target_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic              op_ok;
    logic              cond;
    logic              accept;
    logic              taken;
    logic [DATA_W-1:0] loop_dec;

    assign loop_dec = ra_val - DATA_W'(1);

    // Decode the branch opcode and pick the condition it tests
    always_comb begin
        op_ok = 1'b0;
        cond  = 1'b0;
        unique case (bu_op)
            OP_JZ:   begin op_ok = 1'b1; cond = flags[0];   end
            OP_JN:   begin op_ok = 1'b1; cond = flags[1];   end
            OP_JC:   begin op_ok = 1'b1; cond = flags[2];   end
            OP_JV:   begin op_ok = 1'b1; cond = flags[3];   end
            OP_LOOP: begin op_ok = 1'b1; cond = |loop_dec;  end
            default: begin op_ok = 1'b0; cond = 1'b0;       end
        endcase
    end

    // Instructions arriving while flushing are wrong-path and are ignored
    assign accept = ex_valid & ~stall & (state_q == IDLE) & op_ok;
    assign taken  = accept & cond;

    assign loop_wr_en   = accept & (bu_op == OP_LOOP);
    assign loop_wr_data = loop_dec;

    // Flush sequencer next state; flush outputs are decoded from the state
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_INIT;
                end
            end
            FLUSH: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (!stall) begin
                    if (fcnt_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    // Redirect and counter next state; a redirect pulses for one cycle and
    // is never asserted by a stalled cycle since taken already needs ~stall
    always_comb begin
        pc_load_d    = taken;
        pc_target_d  = taken ? rb_val : pc_target_q;
        branch_cnt_d = sat_inc(branch_cnt_q, accept);
        taken_cnt_d  = sat_inc(taken_cnt_q, taken);
    end

    // State and output registers; reset wins over stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fcnt_q       <= 2'd0;
            pc_load_q    <= 1'b0;
            pc_target_q  <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            pc_load_q    <= pc_load_d;
            pc_target_q  <= pc_target_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign pc_load    = pc_load_q;
    assign pc_target  = pc_target_q;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model. A second instance with 4-bit counters covers saturation.
module tb_branch_resolve_unit;

    localparam int DW  = 8;
    localparam int FC  = 2;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ex_valid, stall;
    logic [2:0]    bu_op;
    logic [3:0]    flags;
    logic [DW-1:0] ra_val, rb_val;

    logic          pc_load, flush_if_id, flush_id_ex, loop_wr_en;
    logic [DW-1:0] pc_target, loop_wr_data;
    logic [CW-1:0] branch_cnt, taken_cnt;

    logic           s_pc_load, s_flush_if_id, s_flush_id_ex, s_loop_wr_en;
    logic [DW-1:0]  s_pc_target, s_loop_wr_data;
    logic [CWS-1:0] s_branch_cnt, s_taken_cnt;

    branch_resolve_unit #(.DATA_W(DW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
        .bu_op(bu_op), .flags(flags), .ra_val(ra_val), .rb_val(rb_val),
        .pc_load(pc_load), .pc_target(pc_target),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .loop_wr_en(loop_wr_en), .loop_wr_data(loop_wr_data),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_resolve_unit #(.DATA_W(DW), .FLUSH_CYCLES(FC), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
        .bu_op(bu_op), .flags(flags), .ra_val(ra_val), .rb_val(rb_val),
        .pc_load(s_pc_load), .pc_target(s_pc_target),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .loop_wr_en(s_loop_wr_en), .loop_wr_data(s_loop_wr_data),
        .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_pc_load   = 1'b0;
    int m_pc_target = 0;
    int m_busy      = 0;   // unstalled flush cycles still owed
    int m_nb        = 0;   // branches accepted since reset
    int m_nt        = 0;   // branches taken since reset

    function automatic bit m_accept();
        return ex_valid && !stall && (m_busy == 0) && (bu_op >= 3'd1) && (bu_op <= 3'd5);
    endfunction

    function automatic bit m_cond();
        case (bu_op)
            3'd1: return flags[0];
            3'd2: return flags[1];
            3'd3: return flags[2];
            3'd4: return flags[3];
            3'd5: return ra_val != 8'd1;   // ra-1 is zero only for ra==1
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    initial forever begin
        bit acc, tk;
        @(posedge clk);
        if (rst) begin
            m_pc_load = 1'b0; m_pc_target = 0; m_busy = 0; m_nb = 0; m_nt = 0;
        end else begin
            acc = m_accept();
            tk  = acc && m_cond();
            m_pc_load = tk;
            if (tk) m_pc_target = int'(rb_val);
            if (m_busy > 0) begin
                if (!stall) m_busy--;
            end else if (tk) begin
                m_busy = FC;
            end
            m_nb += int'(acc);
            m_nt += int'(tk);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        bit acc;
        @(negedge clk);
        if (chk_en) begin
            acc = m_accept();
            chk("pc_load",      32'(pc_load),      32'(m_pc_load));
            chk("pc_target",    32'(pc_target),    32'(m_pc_target));
            chk("flush_if_id",  32'(flush_if_id),  32'(m_busy > 0));
            chk("flush_id_ex",  32'(flush_id_ex),  32'(m_busy > 0));
            chk("loop_wr_en",   32'(loop_wr_en),   32'(acc && bu_op == 3'd5));
            chk("loop_wr_data", 32'(loop_wr_data), 32'((int'(ra_val) + 255) % 256));
            chk("branch_cnt",   32'(branch_cnt),   32'(sat(m_nb, CW)));
            chk("taken_cnt",    32'(taken_cnt),    32'(sat(m_nt, CW)));
            chk("s_pc_load",    32'(s_pc_load),    32'(m_pc_load));
            chk("s_flush",      32'(s_flush_id_ex), 32'(m_busy > 0));
            chk("s_branch_cnt", 32'(s_branch_cnt), 32'(sat(m_nb, CWS)));
            chk("s_taken_cnt",  32'(s_taken_cnt),  32'(sat(m_nt, CWS)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit ev, input bit st, input logic [2:0] op,
                          input logic [3:0] fl, input logic [7:0] ra, input logic [7:0] rb);
        ex_valid = ev; stall = st; bu_op = op; flags = fl; ra_val = ra; rb_val = rb;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 8'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fl_cnt;
        rst = 1'b1;
        idle();
        step();
        chk_en = 1'b1;
        step();
        chk("rst pc_load",    32'(pc_load),     32'd0);
        chk("rst pc_target",  32'(pc_target),   32'd0);
        chk("rst flush",      32'(flush_if_id), 32'd0);
        chk("rst branch_cnt", 32'(branch_cnt),  32'd0);
        chk("rst taken_cnt",  32'(taken_cnt),   32'd0);
        rst = 1'b0;
        step();

        // JZ taken
        set_in(1'b1, 1'b0, 3'b001, 4'b0001, 8'h00, 8'h3C);
        step();
        chk("jz pc_load",    32'(pc_load),     32'd1);
        chk("jz pc_target",  32'(pc_target),   32'h3C);
        chk("jz flush1",     32'(flush_if_id), 32'd1);
        chk("jz branch_cnt", 32'(branch_cnt),  32'd1);
        chk("jz taken_cnt",  32'(taken_cnt),   32'd1);
        idle();
        step();
        chk("jz pulse",  32'(pc_load),     32'd0);
        chk("jz flush2", 32'(flush_id_ex), 32'd1);
        step();
        chk("jz flush end", 32'(flush_if_id), 32'd0);

        // JC not taken
        set_in(1'b1, 1'b0, 3'b011, 4'b1011, 8'h00, 8'h99);
        step();
        chk("jc pc_load",    32'(pc_load),     32'd0);
        chk("jc flush",      32'(flush_if_id), 32'd0);
        chk("jc branch_cnt", 32'(branch_cnt),  32'd2);
        chk("jc taken_cnt",  32'(taken_cnt),   32'd1);

        // LOOP boundaries
        set_in(1'b1, 1'b0, 3'b101, 4'd0, 8'h05, 8'h10);
        #1;
        chk("loop5 wr_en", 32'(loop_wr_en),   32'd1);
        chk("loop5 data",  32'(loop_wr_data), 32'h04);
        step();
        chk("loop5 taken", 32'(pc_load), 32'd1);
        idle(); step(); step();
        set_in(1'b1, 1'b0, 3'b101, 4'd0, 8'h01, 8'h11);
        #1;
        chk("loop1 data", 32'(loop_wr_data), 32'h00);
        step();
        chk("loop1 taken", 32'(pc_load), 32'd0);
        set_in(1'b1, 1'b0, 3'b101, 4'd0, 8'h00, 8'h12);
        #1;
        chk("loop0 data", 32'(loop_wr_data), 32'hFF);
        step();
        chk("loop0 taken",  32'(pc_load),   32'd1);
        chk("loop0 target", 32'(pc_target), 32'h12);
        idle(); step(); step();

        // Wrong-path LOOP during flush after a taken JN
        set_in(1'b1, 1'b0, 3'b010, 4'b0010, 8'h00, 8'h55);
        step();
        set_in(1'b1, 1'b0, 3'b101, 4'd0, 8'h05, 8'h77);
        #1;
        chk("wp wr_en", 32'(loop_wr_en), 32'd0);
        step();
        chk("wp pc_load",    32'(pc_load),    32'd0);
        chk("wp pc_target",  32'(pc_target),  32'h55);
        chk("wp branch_cnt", 32'(branch_cnt), 32'd6);
        step();
        idle();
        chk("wp taken_cnt", 32'(taken_cnt), 32'd4);
        step();

        // Stall in the first flush cycle
        set_in(1'b1, 1'b0, 3'b100, 4'b1000, 8'h00, 8'h21);
        step();
        fl_cnt = int'(flush_if_id);
        set_in(1'b0, 1'b1, 3'd0, 4'd0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            fl_cnt += int'(flush_if_id);
            if (i == 0) chk("stall pc_load", 32'(pc_load), 32'd0);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            fl_cnt += int'(flush_if_id);
        end
        chk("stall flush len", 32'(fl_cnt), 32'd5);
        set_in(1'b1, 1'b1, 3'b100, 4'b1000, 8'h00, 8'h44);
        step();
        chk("stalled jv pc_load", 32'(pc_load),    32'd0);
        chk("stalled jv count",   32'(branch_cnt), 32'd7);
        idle();
        step();

        // Reset in the middle of a flush
        set_in(1'b1, 1'b0, 3'b001, 4'b0001, 8'h00, 8'h66);
        step();
        rst = 1'b1;
        idle();
        step();
        chk("midrst flush",     32'(flush_if_id), 32'd0);
        chk("midrst pc_target", 32'(pc_target),   32'd0);
        chk("midrst taken_cnt", 32'(taken_cnt),   32'd0);
        rst = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                   3'($urandom_range(0, 7)), 4'($urandom),
                   ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom),
                   8'($urandom));
            step();
        end
        rst = 1'b0;

        // Counter saturation on the 4-bit instance
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 1'b0, 3'b001, 4'b0001, 8'h00, 8'(i));
            step();
            idle();
            step();
            step();
            if (i == 13) chk("sat 14", 32'(s_taken_cnt), 32'hE);
        end
        chk("sat taken",    32'(s_taken_cnt),  32'hF);
        chk("sat branch",   32'(s_branch_cnt), 32'hF);
        chk("wide taken",   32'(taken_cnt),    32'd17);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
